// File: rtl/uart_pkg.sv
// Shared constants for the UART blocks: state encoding, LED codes and the
// oversampling tick divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } rx_state_t;

  localparam logic [2:0] LED_IDLE  = 3'b001;
  localparam logic [2:0] LED_START = 3'b010;
  localparam logic [2:0] LED_DATA  = 3'b011;
  localparam logic [2:0] LED_STOP  = 3'b100;
  localparam logic [2:0] LED_BREAK = 3'b111;

  localparam int OVERSAMPLE = 16;

  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (OVERSAMPLE * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-clock tick every DIV clocks, held at zero
// while clear is high so the first tick lands DIV clocks after release.
module baud_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      cnt <= '0;
    else if (clear || cnt == LAST) cnt <= '0;
    else                           cnt <= cnt + W'(1);
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; mid-bit sampling, one-clock
// rxrdy / frame_err strobes.
//   state      | meaning
//   IDLE       | waiting for a high-to-low transition on the line
//   START      | timing to mid start bit to reject glitches
//   DATA       | sampling 8 data bits, LSB first
//   STOP       | checking the stop bit at mid bit
//   BREAK_WAIT | line stuck low after a bad stop bit; wait for high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       frame_err,
  output logic [2:0] rx_leds
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  rx_state_t  state, state_nxt;
  logic       rx_s1, rx_s2, rx_prev;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       tick, tick_clr, fall;
  logic       os_clr, bit_clr, shift_en, load, err;

  // Synchronizer resets low so a line held low through reset never looks like a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b0;
      rx_s2   <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign fall     = rx_prev & ~rx_s2;
  assign tick_clr = (state == IDLE);

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    os_clr    = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    load      = 1'b0;
    err       = 1'b0;
    rx_leds   = LED_IDLE;
    case (state)
      IDLE: begin
        rx_leds = LED_IDLE;
        if (fall) begin
          state_nxt = START;
          os_clr    = 1'b1;
        end
      end
      START: begin
        rx_leds = LED_START;
        if (tick && os_cnt == 4'd7) begin
          if (!rx_s2) begin
            state_nxt = DATA;
            os_clr    = 1'b1;
            bit_clr   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        rx_leds = LED_DATA;
        if (tick && os_cnt == 4'd15) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        rx_leds = LED_STOP;
        if (tick && os_cnt == 4'd15) begin
          load      = rx_s2;
          err       = ~rx_s2;
          state_nxt = rx_s2 ? IDLE : BREAK_WAIT;
        end
      end
      BREAK_WAIT: begin
        rx_leds = LED_BREAK;
        if (rx_s2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rxrdy     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (os_clr)    os_cnt <= '0;
      else if (tick) os_cnt <= os_cnt + 4'd1;
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shift <= {rx_s2, shift[7:1]};
      if (load)     rx_data <= shift;
      rxrdy     <= load;
      frame_err <= err;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=2 (32 clocks per bit).
module tb_uart_rx;

  localparam int BIT = 32;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         n_rdy;
    int         n_err;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rxrdy;
  logic       frame_err;
  logic [2:0] rx_leds;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  int last_rdy_cyc = -1;
  int start_cyc = 0;
  logic       prev_rdy = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_q[$];
  vec_t       vecs[8];

  uart_rx #(.CLK_FREQ(3_200_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rxrdy     (rxrdy),
    .frame_err (frame_err),
    .rx_leds   (rx_leds)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every good frame queues its byte; strobes must match in order.
  always @(negedge clk) begin
    if (rxrdy || frame_err) check("strobe_exclusive", int'(rxrdy & frame_err), 0);
    if (rxrdy) begin
      rdy_cnt++;
      last_rdy_cyc = cyc;
      check("rxrdy_width", int'(prev_rdy), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rxrdy: got rx_data %0h, expected no strobe", rx_data);
      end else begin
        last_good = exp_q.pop_front();
        check("rx_data", rx_data, last_good);
      end
    end
    if (frame_err) begin
      err_cnt++;
      check("frame_err_width", int'(prev_err), 0);
      check("rx_data_on_err", rx_data, last_good);
    end
    prev_rdy = rxrdy;
    prev_err = frame_err;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (stop) exp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 rx = fr[i];
      if (i == 0) start_cyc = cyc;
      repeat (bc - 1) @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  initial begin
    int r0, e0, n_good, n_bad, bc, gap;
    logic [7:0] b;
    logic       s;
    logic [9:0] fr;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    vecs[4] = '{8'h55, 1'b0, 0, 1, 8'h3C};
    vecs[5] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[6] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[7] = '{8'h80, 1'b1, 1, 0, 8'h80};

    #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rxrdy", int'(rxrdy), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_leds", rx_leds, 3'b001);
    rst = 1'b1;
    idle(40);

    for (int i = 0; i < 8; i++) begin
      r0 = rdy_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].stop, BIT);
      idle(48);
      check($sformatf("vec%0d_rdy_count", i), rdy_cnt - r0, vecs[i].n_rdy);
      check($sformatf("vec%0d_err_count", i), err_cnt - e0, vecs[i].n_err);
      check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
      if (i == 0) begin
        checks++;
        if (last_rdy_cyc - start_cyc < 304 || last_rdy_cyc - start_cyc > 308) begin
          errors++;
          $display("FAIL a5_latency: got %0d clocks, expected 304..308", last_rdy_cyc - start_cyc);
        end
      end
    end

    // Back-to-back frames with no idle gap
    r0 = rdy_cnt;
    send_frame(8'h00, 1'b1, BIT);
    send_frame(8'hFF, 1'b1, BIT);
    send_frame(8'h3C, 1'b1, BIT);
    idle(48);
    check("b2b_rdy_count", rdy_cnt - r0, 3);
    check("b2b_rx_data", rx_data, 8'h3C);

    // Bad stop bit followed by a held-low break
    r0 = rdy_cnt;
    e0 = err_cnt;
    send_frame(8'h55, 1'b0, BIT);
    repeat (3 * BIT) @(posedge clk);
    #1;
    check("break_leds", rx_leds, 3'b111);
    check("break_err_count", err_cnt - e0, 1);
    check("break_rdy_count", rdy_cnt - r0, 0);
    check("break_rx_data", rx_data, 8'h3C);
    idle(6);
    check("break_release_leds", rx_leds, 3'b001);

    // Short glitch, then a real frame
    r0 = rdy_cnt;
    e0 = err_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (8) @(posedge clk);
    #1 rx = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    check("glitch_leds", rx_leds, 3'b001);
    check("glitch_rdy_count", rdy_cnt - r0, 0);
    check("glitch_err_count", err_cnt - e0, 0);
    send_frame(8'h81, 1'b1, BIT);
    idle(48);
    check("post_glitch_rdy_count", rdy_cnt - r0, 1);
    check("post_glitch_rx_data", rx_data, 8'h81);

    // Reset during data bit 4 of 0x7E
    fr = {1'b1, 8'h7E, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 rx = fr[i];
      repeat (BIT - 1) @(posedge clk);
    end
    repeat (16) @(posedge clk);
    #1;
    check("midframe_leds_data", rx_leds, 3'b011);
    rst = 1'b0;
    #1;
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_rxrdy", int'(rxrdy), 0);
    check("midreset_frame_err", int'(frame_err), 0);
    check("midreset_leds", rx_leds, 3'b001);
    rx = 1'b1;
    last_good = 8'h00;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    r0 = rdy_cnt;
    idle(40);
    send_frame(8'h12, 1'b1, BIT);
    idle(48);
    check("after_reset_rdy_count", rdy_cnt - r0, 1);
    check("after_reset_rx_data", rx_data, 8'h12);

    // Line held low across reset release
    r0 = rdy_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    last_good = 8'h00;
    repeat (80) @(posedge clk);
    #1;
    check("lowrst_rdy_count", rdy_cnt - r0, 0);
    check("lowrst_err_count", err_cnt - e0, 0);
    check("lowrst_leds", rx_leds, 3'b001);
    idle(40);
    send_frame(8'hC3, 1'b1, BIT);
    idle(48);
    check("lowrst_c3_rdy_count", rdy_cnt - r0, 1);
    check("lowrst_c3_rx_data", rx_data, 8'hC3);

    // Random frames with +/-3% bit period and random gaps
    r0 = rdy_cnt;
    e0 = err_cnt;
    n_good = 0;
    n_bad = 0;
    for (int k = 0; k < 30; k++) begin
      b   = 8'($urandom);
      s   = ($urandom_range(0, 7) != 0);
      bc  = $urandom_range(31, 33);
      send_frame(b, s, bc);
      if (s) begin
        n_good++;
        gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
        if (gap > 0) idle(gap);
      end else begin
        n_bad++;
        idle(32 + $urandom_range(0, 20));
      end
    end
    idle(48);
    check("rand_rdy_count", rdy_cnt - r0, n_good);
    check("rand_err_count", err_cnt - e0, n_bad);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
